// File: rtl/lapido_boot_loader_pkg.sv
// Shared definitions for the LAPIDO program loader: header field width and FSM states.
package lapido_boot_loader_pkg;

  localparam int unsigned LoaderLenWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCheck,
    StDone,
    StError
  } ldr_state_e;

endpackage

// File: rtl/lapido_boot_loader_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; flags the byte that completes a word.
module lapido_boot_loader_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  // The completing byte is merged combinationally so the loader can register the write.
  assign word_valid = byte_valid && (cnt_q == 2'd3);
  assign word       = {shift_q, byte_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_data};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/lapido_boot_loader.sv
// Loads instruction memory from a length-prefixed, XOR-checksummed byte stream while
// holding the core in reset; the core is released only after a good load.
module lapido_boot_loader
  import lapido_boot_loader_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH       = LoaderLenWidth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       core_rst_n,
  output logic                       done,
  output logic                       error,
  output logic [LEN_WIDTH-1:0]       words_loaded
);

  localparam logic [LEN_WIDTH:0] MaxLen = (LEN_WIDTH + 1)'(1) << IMEM_ADDR_WIDTH;

  ldr_state_e           state_q;
  logic [7:0]           len_hi_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [7:0]           checksum_q;

  logic                 xfer;
  logic                 start_ok;
  logic [LEN_WIDTH-1:0] len_full;
  logic                 word_valid;
  logic [31:0]          word;

  assign xfer     = in_valid && in_ready;
  assign start_ok = start && (state_q inside {StIdle, StDone, StError});
  assign len_full = LEN_WIDTH'({len_hi_q, in_data});

  lapido_boot_loader_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (xfer && (state_q == StData)),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      len_hi_q     <= '0;
      len_q        <= '0;
      checksum_q   <= '0;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_rst_n   <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      // The write pulse runs independently of the FSM so the last word survives entering CHECK.
      imem_we <= 1'b0;
      if (imem_we) begin
        words_loaded <= words_loaded + LEN_WIDTH'(1);
      end
      if (word_valid) begin
        imem_we    <= 1'b1;
        imem_addr  <= words_loaded[IMEM_ADDR_WIDTH-1:0];
        imem_wdata <= word;
      end

      if (start_ok) begin
        state_q      <= StLenHi;
        in_ready     <= 1'b1;
        core_rst_n   <= 1'b0;
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= '0;
        checksum_q   <= '0;
      end else begin
        unique case (state_q)
          StLenHi: begin
            if (xfer) begin
              len_hi_q <= in_data;
              state_q  <= StLenLo;
            end
          end
          StLenLo: begin
            if (xfer) begin
              len_q <= len_full;
              if ({1'b0, len_full} > MaxLen) begin
                state_q  <= StError;
                in_ready <= 1'b0;
                error    <= 1'b1;
              end else if (len_full == '0) begin
                state_q <= StCheck;
              end else begin
                state_q <= StData;
              end
            end
          end
          StData: begin
            if (xfer) begin
              checksum_q <= checksum_q ^ in_data;
              // words_loaded is current here: the previous write pulse is at least 3 cycles old.
              if (word_valid && ((words_loaded + LEN_WIDTH'(1)) == len_q)) begin
                state_q <= StCheck;
              end
            end
          end
          StCheck: begin
            if (xfer) begin
              in_ready <= 1'b0;
              if (in_data == checksum_q) begin
                state_q    <= StDone;
                done       <= 1'b1;
                core_rst_n <= 1'b1;
              end else begin
                state_q <= StError;
                error   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
